// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 execute-stage definitions (M-op funct3 codes, muldiv FSM states).
package rv_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIN, MD_DONE} md_state_e;
endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: add/subtract with carry-out shared by multiply accumulate and divide trial subtract.
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] bx;
    assign bx = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, bx} + (W+1)'(sub);
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide, stalls the pipeline until one result is returned.
module ex_muldiv_unit
    import rv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o
);
    md_state_e          state;
    logic [4:0]         count;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic               neg;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH:0]   acc;
    logic               is_div, sa, sb, b_zero, special;
    logic [WIDTH-1:0]   mag_a, mag_b, special_res;
    logic [WIDTH:0]     as_a, as_sum;
    logic               as_cout;
    logic [2*WIDTH:0]   shl, acc_next;
    logic [2*WIDTH-1:0] raw, fixed;

    assign is_div = funct3_i[2];
    assign sa = op_a_i[WIDTH-1] & (funct3_i == F3_MULH || funct3_i == F3_MULHSU ||
                                   funct3_i == F3_DIV || funct3_i == F3_REM);
    assign sb = op_b_i[WIDTH-1] & (funct3_i == F3_MULH || funct3_i == F3_DIV || funct3_i == F3_REM);
    assign mag_a = sa ? -op_a_i : op_a_i;
    assign mag_b = sb ? -op_b_i : op_b_i;
    assign b_zero = op_b_i == '0;
    assign special = is_div & (b_zero | (!funct3_i[0] & op_a_i == {1'b1, {(WIDTH-1){1'b0}}} & op_b_i == '1));
    assign special_res = b_zero ? (funct3_i[1] ? op_a_i : '1) : (funct3_i[1] ? '0 : op_a_i);

    // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
    assign shl = {acc[2*WIDTH-1:0], 1'b0};
    assign as_a = funct3[2] ? shl[2*WIDTH:WIDTH] : acc[2*WIDTH:WIDTH];

    muldiv_addsub #(.W(WIDTH+1)) u_addsub (
        .a    (as_a),
        .b    ({1'b0, opnd}),
        .sub  (funct3[2]),
        .sum  (as_sum),
        .cout (as_cout)
    );

    assign acc_next = funct3[2] ? (as_cout ? {as_sum, shl[WIDTH-1:1], 1'b1} : shl)
                                : (acc[0] ? {1'b0, as_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]});
    assign raw = funct3[2] ? {{WIDTH{1'b0}}, funct3[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0]}
                           : acc[2*WIDTH-1:0];
    assign fixed = neg ? -raw : raw;

    assign stall_o = (state == MD_IDLE & start_i & !flush_i) | state == MD_CALC | state == MD_FIN;
    assign busy_o = state != MD_IDLE;
    assign done_o = state == MD_DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MD_IDLE;
            count    <= '0;
            funct3   <= '0;
            rd       <= '0;
            neg      <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (flush_i) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start_i) begin
                    funct3 <= funct3_i;
                    rd     <= rd_i;
                    neg    <= (is_div & funct3_i[1]) ? sa : sa ^ sb;
                    opnd   <= is_div ? mag_b : mag_a;
                    acc    <= {{(WIDTH+1){1'b0}}, is_div ? mag_a : mag_b};
                    count  <= '0;
                    if (special) begin
                        result_o <= special_res;
                        rd_o     <= rd_i;
                        state    <= MD_DONE;
                    end else begin
                        state <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= MD_FIN;
                end
                MD_FIN: begin
                    result_o <= (funct3[2] || funct3[1:0] == 2'b00) ? fixed[WIDTH-1:0] : fixed[2*WIDTH-1:WIDTH];
                    rd_o     <= rd;
                    state    <= MD_DONE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and model-checked RV32M ops, scoreboarded results, flush and async reset.
module tb_ex_muldiv_unit;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    logic        clk, reset, start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i, op_b_i;
    logic [4:0]  rd_i;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    exp_t        sb_q[$];
    int          compared, mismatched;

    ex_muldiv_unit dut (
        .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, xa, xb, p;
        int ia, ib;
        ua = {32'b0, a};
        ub = {32'b0, b};
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = xa * xb; return p[63:32]; end
            3'd2: begin p = xa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 0;
        return 33;
    endfunction

    // Drives one op, pushes its expectation, then waits (bounded) for done_o and scores it.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] want);
        exp_t e;
        int   n;
        bit   got, stall_ok;
        @(negedge clk);
        check("idle_no_done", done_o, 0);
        funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd; start_i = 1;
        #1;
        check("accept_stall", stall_o, 1);
        e.res = want; e.rd = rd; e.lat = latency(f3, a, b);
        sb_q.push_back(e);
        @(posedge clk);
        #1 start_i = 0;
        n = 0; got = 0; stall_ok = 1;
        while (!got && n < 60) begin
            @(negedge clk);
            if (done_o) got = 1;
            else begin
                if (stall_o !== 1'b1 || busy_o !== 1'b1) stall_ok = 0;
                n++;
            end
        end
        check("done_seen", got, 1);
        e = sb_q.pop_front();
        check("latency", n, e.lat);
        check("stall_while_busy", stall_ok, 1);
        check("result", result_o, e.res);
        check("rd", rd_o, e.rd);
        check("done_stall_low", stall_o, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        compared = 0; mismatched = 0;
        reset = 1; start_i = 0; flush_i = 0; funct3_i = 0; op_a_i = 0; op_b_i = 0; rd_i = 0;
        repeat (2) @(negedge clk);
        check("rst_stall", stall_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_result", result_o, 0);
        check("rst_rd", rd_o, 0);
        reset = 0;

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd5, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd6, 32'd2);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFD);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFF);
        run_op(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF);
        run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0);

        for (int f = 0; f < 8; f++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(3'(f), ra, rb, 5'(13 + f), model(3'(f), ra, rb));
        end

        // Flush at count=10: no result, prior result held, then a fresh op completes.
        run_op(3'd0, 32'd3, 32'd5, 5'd21, 32'd15);
        @(negedge clk);
        funct3_i = 3'd0; op_a_i = 32'd9; op_b_i = 32'd9; rd_i = 5'd22; start_i = 1;
        @(posedge clk);
        #1 start_i = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1;
        @(posedge clk);
        #1 flush_i = 0;
        check("flush_busy", busy_o, 0);
        check("flush_stall", stall_o, 0);
        check("flush_done", done_o, 0);
        check("flush_result_held", result_o, 32'd15);
        check("flush_rd_held", rd_o, 5'd21);
        run_op(3'd5, 32'd1000, 32'd10, 5'd23, 32'd100);

        // Asynchronous reset mid-CALC clears every output without a clock edge.
        @(negedge clk);
        funct3_i = 3'd5; op_a_i = 32'd77; op_b_i = 32'd3; rd_i = 5'd24; start_i = 1;
        @(posedge clk);
        #1 start_i = 0;
        repeat (5) @(negedge clk);
        #2 reset = 1;
        #1;
        check("arst_stall", stall_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_result", result_o, 0);
        check("arst_rd", rd_o, 0);
        @(negedge clk);
        reset = 0;
        run_op(3'd0, 32'd12345, 32'd678, 5'd25, model(3'd0, 32'd12345, 32'd678));
        run_op(3'd4, 32'hFFFFFC00, 32'd7, 5'd26, model(3'd4, 32'hFFFFFC00, 32'd7));

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the ID/EX pipeline register outputs (operands, funct3, rd) whenever the decoded instruction is an M-extension op. It holds the pipeline with a stall while it computes, then returns one result with its destination register. Multiply and divide use a shared radix-2 shift/add-subtract datapath: 32 iteration cycles plus one sign-fix cycle, with early completion for divide special cases.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start_i  in  1  ID/EX holds a valid M-op this cycle
- funct3_i  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a_i  in  WIDTH  rs1 value, after forwarding
- op_b_i  in  WIDTH  rs2 value, after forwarding
- rd_i  in  5  destination register
- flush_i  in  1  kill any accepted or in-flight op
- stall_o  out  1  freezes PC, IF/ID and ID/EX
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle result-valid pulse
- result_o  out  WIDTH  result; valid while done_o is high
- rd_o  out  5  destination register of the result

## Operation
- States:
  - IDLE: waiting for a new op.
  - CALC: iterating; 5-bit count runs 0..31.
  - FIN: sign correction and hi/lo select.
  - DONE: result presented.
- IDLE, start_i=1, flush_i=0:
  - Latch funct3 and rd.
  - Latch the magnitudes of op_a/op_b. An operand is treated as signed for MULH, DIV and REM (both operands) and for MULHSU (op_a only).
  - Latch the result signs:
    - Product sign: sa^sb.
    - Quotient sign: sa^sb.
    - Remainder sign: sa.
  - Go to CALC, except for the divide special cases below.
- Divide special cases, decided in IDLE, go straight to DONE:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Multiply, each CALC cycle:
  - If the lsb of the multiplier is 1, add the multiplicand into the upper half of a 65-bit accumulator.
  - Shift the accumulator right by 1.
- Divide, each CALC cycle (restoring):
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem using 33-bit arithmetic.
  - If the result is non-negative, keep it and set the quotient lsb.
- CALC, count=31: go to FIN.
- FIN:
  - Two's-complement negate the 64-bit product, quotient or remainder per the latched sign.
  - Select the low word for MUL and the high word for MULH/MULHSU/MULHU.
  - Register the result into result_o/rd_o and go to DONE.
- DONE: done_o=1, then go to IDLE.
- start_i while not IDLE: ignored. ID/EX is frozen, so the same instruction is still there after done; the EX-stage decode masks start_i for that instruction once done_o has fired.
- flush_i in any state: next state is IDLE, and no done_o is produced. flush_i takes priority over start_i in IDLE.
- reset at any time: next state is IDLE, and all outputs are cleared.

## Timing
- Reset values: stall_o=0, busy_o=0, done_o=0, result_o=0, rd_o=0, state IDLE, count 0.
- Edge numbering: E0 is the accepting edge.
  - Normal op: CALC on edges E1..E32, FIN→DONE at E33, done_o high for the cycle E33–E34, IDLE at E34.
  - Special case: DONE at E0, done_o high E0–E1.
- stall_o is combinational:
  - High when (IDLE & start_i & !flush_i), or in CALC, or in FIN.
  - Low in DONE, so the pipeline advances on the same edge the result is written back.
- result_o and rd_o are registered and hold their value until the next FIN or special-case load.
- All arithmetic is modulo 2^64 for the product and modulo 2^32 for the quotient/remainder. No exceptions are raised.

## Structure
- Shared package (rv_pkg):
  - funct3 localparams for the eight M-ops.
  - The state enum for this unit.
  - WIDTH default.
- One natural sub-module, muldiv_addsub: a 33-bit add/subtract with carry-out, shared by the multiply accumulate and the divide trial subtraction.
- Everything else stays in ex_muldiv_unit: FSM, counter, operand/sign registers, fix-up logic.

## Test plan
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB, done_o exactly 33 cycles after the accept edge, stall_o high for cycles 0–32.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with done_o one cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, also in one cycle.
- flush_i asserted at count=10 → IDLE next cycle, no done_o, stall_o low. A new start the following cycle completes normally with the correct rd_o.
- reset asserted mid-CALC → all outputs 0 immediately (asynchronous). After release, a back-to-back MUL then DIV gives correct results with stall/done timing as specified.
